// File: rtl/seq_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seq_pkg
// Description : Shared types and constants for the Y86-64 sequential
//               controller: state encoding, instruction codes, status codes.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Sequencer states; 3 bits cover all eight states exactly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Y86-64 instruction codes
  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  // Processor status codes
  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  // Instructions that touch data memory and therefore need a MEM phase.
  function automatic logic is_mem_icode(input logic [3:0] icode);
    return (icode == I_RMMOV) || (icode == I_MRMOV) || (icode == I_CALL) ||
           (icode == I_RET)   || (icode == I_PUSH)  || (icode == I_POP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_stage_ctrl_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : seq_pc_sel
// Description : Next-PC selection for Y86-64: call target, taken jump
//               target, return address or sequential PC.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pc_sel
  import seq_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] next_pc
);

  // Priority mux: call/taken-jump use the constant, ret uses the popped
  // address, everything else falls through to the sequential PC.
  always_comb begin
    next_pc = valP;
    if ((icode == I_CALL) || ((icode == I_JXX) && cnd)) begin
      next_pc = valC;
    end else if (icode == I_RET) begin
      next_pc = valM;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl
// Description : Multi-cycle sequencer for the Y86-64 SEQ processor. Owns the
//               architectural PC, steps each instruction through
//               F/D/E/M/W/PC-update with one stage strobe per cycle and
//               records the processor status code.
// Options     : SEQ_PERF_CNT_EN - build saturating cycle/instruction
//               counters; when undefined both counter ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_ctrl
  import seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valM,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic [63:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             mem_req,
  output logic [1:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t      state;
  logic [63:0] next_pc;

  seq_pc_sel u_pc_sel (
    .icode   (icode),
    .cnd     (cnd),
    .valC    (valC),
    .valP    (valP),
    .valM    (valM),
    .next_pc (next_pc)
  );

  // Strobes are pure decodes of the state register, so they are one-hot by
  // construction and drop immediately when the asynchronous reset fires.
  assign fetch_en  = (state == S_FETCH);
  assign decode_en = (state == S_DECODE);
  assign exec_en   = (state == S_EXEC);
  assign mem_req   = (state == S_MEM);
  assign wb_en     = (state == S_WB);
  assign halted    = (state == S_HALT);

  // Sequencer: state transitions, fault capture into stat, PC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      stat  <= STAT_AOK;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          // Fetch faults are prioritised: address error, then invalid
          // instruction, then the halt instruction itself.
          if (imem_error) begin
            stat  <= STAT_ADR;
            state <= S_HALT;
          end else if (!instr_valid) begin
            stat  <= STAT_INS;
            state <= S_HALT;
          end else if (icode == I_HALT) begin
            stat  <= STAT_HLT;
            state <= S_HALT;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          state <= is_mem_icode(icode) ? S_MEM : S_WB;
        end
        S_MEM: begin
          // Wait for the data memory; an error aborts before write-back so
          // the register file and PC keep the faulting instruction's view.
          if (mem_ack) begin
            if (dmem_error) begin
              stat  <= STAT_ADR;
              state <= S_HALT;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: state <= S_PCUPD;
        S_PCUPD: begin
          pc    <= next_pc;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ins_cnt;

  // Saturating performance counters: active cycles and retired instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      if ((state != S_IDLE) && (state != S_HALT) && (cyc_cnt != '1)) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
      if ((state == S_PCUPD) && (ins_cnt != '1)) begin
        ins_cnt <= ins_cnt + CNT_W'(1);
      end
    end
  end

  assign cycle_count = cyc_cnt;
  assign instr_count = ins_cnt;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_stage_ctrl
// Description : Scoreboard bench for seq_stage_ctrl. The driver pushes the
//               hand-computed outcome of each instruction; a monitor pops it
//               at the next FETCH (or on entry to HALT) and compares PC,
//               status, the per-cycle strobe trace and the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stage_ctrl;
  import seq_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_0000_1000;
  localparam int          CW  = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, instr_valid, imem_error, cnd, mem_ack, dmem_error;
  logic [3:0]    icode;
  logic [63:0]   valC, valP, valM;
  logic [63:0]   pc;
  logic          fetch_en, decode_en, exec_en, wb_en, mem_req, halted;
  logic [1:0]    stat;
  logic [CW-1:0] cycle_count, instr_count;

  seq_stage_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
    .valC(valC), .valP(valP), .valM(valM), .mem_ack(mem_ack),
    .dmem_error(dmem_error), .pc(pc), .fetch_en(fetch_en),
    .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .mem_req(mem_req), .stat(stat), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        halted;
    logic [63:0] trace;
    int          len;
    logic [63:0] icnt;
    logic [63:0] cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_icnt = 0;
  int   exp_cyc = 0;

  // memory responder configuration, set per instruction by the driver
  int   mem_delay = 1;
  logic derr_cfg = 1'b0;
  logic stray_cfg = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int v);
`ifdef SEQ_PERF_CNT_EN
    return 64'(v);
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [3:0] enc(input logic [4:0] s);
    case (s)
      5'b10000: return 4'd1;
      5'b01000: return 4'd2;
      5'b00100: return 4'd3;
      5'b00010: return 4'd4;
      5'b00001: return 4'd5;
      5'b00000: return 4'd0;
      default:  return 4'hF;
    endcase
  endfunction

  // Data memory responder: acks after mem_delay cycles of mem_req.
  initial begin
    int mc = 0;
    mem_ack = 1'b0;
    dmem_error = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (mem_req) begin
        mc++;
        mem_ack    = (mc >= mem_delay);
        dmem_error = mem_ack && derr_cfg;
      end else begin
        mc = 0;
        mem_ack    = stray_cfg;
        dmem_error = stray_cfg;
      end
    end
  end

  // Monitor: builds the strobe trace and checks at each FETCH / HALT entry.
  initial begin
    logic [63:0] trace = '0;
    int          len = 0;
    bit          tracing = 0;
    bit          hseen = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tracing = 0;
        hseen   = 0;
      end else if ((halted && !hseen) || (fetch_en && tracing)) begin
        if (halted) hseen = 1;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: DUT event with no expectation at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("pc", pc, e.pc);
          chk("stat", {62'd0, stat}, {62'd0, e.stat});
          chk("halted", {63'd0, halted}, {63'd0, e.halted});
          chk("trace", trace, e.trace);
          chk("trace_len", 64'(len), 64'(e.len));
          chk("instr_count", 64'(instr_count), e.icnt);
          chk("cycle_count", 64'(cycle_count), e.cyc);
        end
      end
      if (rst_n && fetch_en) begin
        trace   = '0;
        len     = 0;
        tracing = 1;
      end
      if (tracing && !halted) begin
        trace = {trace[59:0], enc({fetch_en, decode_en, exec_en, mem_req, wb_en})};
        len++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; stray_cfg = 1'b0;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_stat", {62'd0, stat}, 64'd0);
    chk("rst_strobes", {58'd0, fetch_en, decode_en, exec_en, mem_req, wb_en, halted}, 64'd0);
    chk("rst_counters", {32'(cycle_count), 32'(instr_count)}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_icnt = 0;
    exp_cyc  = 0;
  endtask

  // Wait for FETCH, present the instruction, record its expected outcome.
  task automatic issue(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                       input logic [63:0] vp, input logic [63:0] vm, input int md,
                       input logic de, input logic ie, input logic iv, input logic st,
                       input bit push, input logic [63:0] epc, input logic [1:0] estat,
                       input logic [63:0] etr, input int elen);
    int   t = 0;
    exp_t e;
    do begin @(posedge clk); #1; t++; end while (!fetch_en && t < 40);
    if (!fetch_en) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: fetch_en=0 required 1 at %0t", $time);
    end
    icode = ic; cnd = c; valC = vc; valP = vp; valM = vm;
    imem_error = ie; instr_valid = iv;
    mem_delay = md; derr_cfg = de; stray_cfg = st;
    if (push) begin
      exp_cyc += elen;
      if (estat == STAT_AOK) exp_icnt++;
      e.pc = epc; e.stat = estat; e.halted = (estat != STAT_AOK);
      e.trace = etr; e.len = elen;
      e.icnt = cnt_exp(exp_icnt); e.cyc = cnt_exp(exp_cyc);
      sbq.push_back(e);
    end
  endtask

  task automatic expect_halt(input logic [63:0] epc);
    int t = 0;
    while (!halted && t < 30) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("halt_terminal", {62'd0, halted, fetch_en}, 64'd2);
    chk("halt_pc_frozen", pc, epc);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; icode = 4'h1; cnd = 1'b0;
    valC = '0; valP = '0; valM = '0; instr_valid = 1'b1; imem_error = 1'b0;

    // Phase A: normal instruction stream
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("idle_hold", {63'd0, fetch_en}, 64'd0);
    start = 1'b1;
    issue(I_IRMOV, 0, 64'h0, 64'h0A, 64'h0, 1, 0, 0, 1, 0, 1, 64'h0A, STAT_AOK, 64'h12350, 5);
    start = 1'b0;
    issue(I_CALL, 0, 64'h38, 64'h13, 64'h0, 3, 0, 0, 1, 0, 1, 64'h38, STAT_AOK, 64'h12344450, 8);
    issue(I_JXX, 1, 64'h21, 64'h2D, 64'h0, 1, 0, 0, 1, 1, 1, 64'h21, STAT_AOK, 64'h12350, 5);
    issue(I_JXX, 0, 64'h21, 64'h2D, 64'h0, 1, 0, 0, 1, 0, 1, 64'h2D, STAT_AOK, 64'h12350, 5);
    issue(I_RET, 0, 64'h0, 64'h36, 64'h55, 1, 0, 0, 1, 0, 1, 64'h55, STAT_AOK, 64'h123450, 6);
    issue(I_MRMOV, 0, 64'h8, 64'h60, 64'h99, 2, 0, 0, 1, 0, 1, 64'h60, STAT_AOK, 64'h1234450, 7);
    issue(I_HALT, 0, 64'h0, 64'h61, 64'h0, 1, 0, 0, 1, 0, 1, 64'h60, STAT_HLT, 64'h1, 1);
    expect_halt(64'h60);

    // Phase B: imem_error with invalid instruction -> ADR wins
    do_reset();
    start = 1'b1;
    issue(I_IRMOV, 0, 64'h0, 64'h0A, 64'h0, 1, 0, 1, 0, 0, 1, RPC, STAT_ADR, 64'h1, 1);
    expect_halt(RPC);

    // Phase C: invalid instruction
    do_reset();
    start = 1'b1;
    issue(I_IRMOV, 0, 64'h0, 64'h0A, 64'h0, 1, 0, 0, 0, 0, 1, RPC, STAT_INS, 64'h1, 1);
    expect_halt(RPC);

    // Phase D: data memory error skips WB and PC update
    do_reset();
    start = 1'b1;
    issue(I_IRMOV, 0, 64'h0, 64'h40, 64'h0, 1, 0, 0, 1, 0, 1, 64'h40, STAT_AOK, 64'h12350, 5);
    issue(I_POP, 0, 64'h0, 64'h42, 64'h77, 2, 1, 0, 1, 0, 1, 64'h40, STAT_ADR, 64'h12344, 5);
    expect_halt(64'h40);

    // Phase E: asynchronous reset during MEM
    do_reset();
    start = 1'b1;
    issue(I_IRMOV, 0, 64'h0, 64'h40, 64'h0, 1, 0, 0, 1, 0, 1, 64'h40, STAT_AOK, 64'h12350, 5);
    issue(I_CALL, 0, 64'h80, 64'h49, 64'h0, 20, 0, 0, 1, 0, 0, 64'h0, STAT_AOK, 64'h0, 0);
    begin
      int t = 0;
      while (!mem_req && t < 20) begin @(posedge clk); #1; t++; end
      chk("mem_req_seen", {63'd0, mem_req}, 64'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async_mem_req", {63'd0, mem_req}, 64'd0);
      chk("async_pc", pc, RPC);
      chk("async_counters", {32'(cycle_count), 32'(instr_count)}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; start = 1'b0;
    end

    begin
      int t = 0;
      while (sbq.size() != 0 && t < 50) begin @(posedge clk); t++; end
      if (sbq.size() != 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
